// File: rtl/calc_engine.sv
// calc_engine: multi-channel add/subtract engine.
// Requests enter over a valid/ready handshake, travel through a fixed-latency
// pipeline and land in a small result FIFO that drains over a second
// valid/ready handshake. Admission is credit based: occupancy counts every
// accepted request that has not yet been popped, so the FIFO cannot overflow.
module calc_engine #(
    parameter int DATA_W     = 8,
    parameter int NUM_CH     = 4,
    parameter int LATENCY    = 2,
    parameter int FIFO_DEPTH = 4,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int OCC_W     = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [CH_W-1:0]   req_ch,
    input  logic              req_op,
    input  logic [DATA_W-1:0] req_x,
    input  logic [DATA_W-1:0] req_y,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [CH_W-1:0]   rsp_ch,
    output logic [DATA_W:0]   rsp_z,
    output logic              busy,
    output logic [OCC_W-1:0]  occupancy
);

    localparam int ENT_W = CH_W + DATA_W + 1;
    localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [PTR_W:0]   PTR_ONE   = (PTR_W + 1)'(1);

    // Reject unsupported configurations while elaborating.
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
        $error("calc_engine: LATENCY must be within 1..4");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("calc_engine: FIFO_DEPTH must be a power of two, at least 2");
    end

    logic                 accept;
    logic                 pop;
    logic                 fifo_wr;
    logic [DATA_W:0]      calc_z;
    logic [OCC_W-1:0]     occ_reg;
    logic [PTR_W:0]       wr_ptr_reg;
    logic [PTR_W:0]       rd_ptr_reg;
    logic [ENT_W-1:0]     head;
    logic [ENT_W-1:0]     mem [FIFO_DEPTH];

    assign req_ready = (occ_reg < DEPTH_OCC);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (wr_ptr_reg != rd_ptr_reg);
    assign pop       = rsp_valid && rsp_ready;
    assign busy      = (occ_reg != '0);
    assign occupancy = occ_reg;

    // Result is computed at capture; the pipeline only carries it along.
    always_comb begin
        calc_z = {1'b0, req_x} + {1'b0, req_y};
        if (req_op) begin
            calc_z = {1'b0, req_x} - {1'b0, req_y};
        end
    end

    // Pipeline stages: valid bits advance every cycle, there is no stall path.
    for (genvar gi = 0; gi < LATENCY; gi++) begin : g_stage
        logic              v_in;
        logic [CH_W-1:0]   ch_in;
        logic [DATA_W:0]   z_in;
        logic              v_reg;
        logic [CH_W-1:0]   ch_reg;
        logic [DATA_W:0]   z_reg;

        if (gi == 0) begin : g_first
            assign v_in  = accept;
            assign ch_in = req_ch;
            assign z_in  = calc_z;
        end else begin : g_next
            assign v_in  = g_stage[gi-1].v_reg;
            assign ch_in = g_stage[gi-1].ch_reg;
            assign z_in  = g_stage[gi-1].z_reg;
        end

        // Stage register; payload only moves alongside a valid token.
        always_ff @(posedge clk) begin
            if (rst) begin
                v_reg <= 1'b0;
            end else begin
                v_reg <= v_in;
            end
            if (v_in) begin
                ch_reg <= ch_in;
                z_reg  <= z_in;
            end
        end
    end

    assign fifo_wr = g_stage[LATENCY-1].v_reg;

    // FIFO storage write; contents need no reset because the pointers gate visibility.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem[wr_ptr_reg[PTR_W-1:0]] <= {g_stage[LATENCY-1].ch_reg, g_stage[LATENCY-1].z_reg};
        end
    end

    // FIFO pointers with an extra wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
        end else begin
            if (fifo_wr) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
            end
        end
    end

    // Credit counter: accepted but not yet popped.
    always_ff @(posedge clk) begin
        if (rst) begin
            occ_reg <= '0;
        end else if (accept && !pop) begin
            occ_reg <= occ_reg + OCC_W'(1);
        end else if (!accept && pop) begin
            occ_reg <= occ_reg - OCC_W'(1);
        end
    end

    // Head entry is shown only while valid so stale memory never leaks out.
    assign head   = mem[rd_ptr_reg[PTR_W-1:0]];
    assign rsp_ch = rsp_valid ? head[ENT_W-1 -: CH_W] : '0;
    assign rsp_z  = rsp_valid ? head[DATA_W:0] : '0;

endmodule

// File: doc/calc_engine.md
Name: calc_engine

Overview:
- Parametrised successor to the single-channel 8-bit add DUT.
- Accepts add/subtract requests from up to NUM_CH logical channels over a valid/ready handshake, computes them in a fixed-latency pipeline, and buffers tagged results in a FIFO.
- The FIFO drains over a second valid/ready handshake.
- Sits behind the testbench interface and is driven either pin-level or by the DPI transactor, which polls the busy flag instead of counting clocks.

Parameters:
- DATA_W, 8: operand width; the result is DATA_W+1 bits.
- NUM_CH, 4: number of channel tags; CH_W = max(1, clog2(NUM_CH)).
- LATENCY, 2: pipeline stages from request accept to FIFO write; legal range 1..4.
- FIFO_DEPTH, 4: result FIFO entries; power of two, at least 2.

Ports:
- clk, in, 1: sole clock; everything is on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- req_valid, in, 1: request present.
- req_ready, out, 1: engine can accept a request this cycle.
- req_ch, in, CH_W: channel tag, returned unchanged with the result.
- req_op, in, 1: 0 = add, 1 = subtract.
- req_x, in, DATA_W: operand x.
- req_y, in, DATA_W: operand y.
- rsp_valid, out, 1: FIFO head is valid.
- rsp_ready, in, 1: consumer accepts the head.
- rsp_ch, out, CH_W: tag of the head entry.
- rsp_z, out, DATA_W+1: result of the head entry.
- busy, out, 1: any request is in the pipeline or the FIFO.
- occupancy, out, clog2(FIFO_DEPTH)+1: in-flight plus buffered entry count.

Behaviour:
- Reset (rst=1 at a rising edge):
  - All pipeline valid bits, FIFO pointers and occupancy clear.
  - Next cycle: req_ready=1, rsp_valid=0, busy=0, occupancy=0.
  - rsp_ch and rsp_z read 0.
  - Reset mid-operation discards every in-flight and buffered result, with no partial output.
- Accept: a request is accepted when req_valid and req_ready are both high at a rising edge. Operands are captured that cycle.
- Arithmetic:
  - add: rsp_z = zero-extended x + zero-extended y. The MSB is the carry.
  - sub: rsp_z = ({1'b0,x} - {1'b0,y}) mod 2^(DATA_W+1). MSB=1 means borrow, i.e. x<y.
- Latency:
  - A request accepted at edge N is written into the FIFO at edge N+LATENCY.
  - rsp_valid is high after edge N+LATENCY if the FIFO was empty.
  - The pipeline never stalls. Valid bits advance every cycle.
- Credit rule:
  - req_ready = (occupancy < FIFO_DEPTH).
  - occupancy counts accepted requests not yet popped from the FIFO.
  - This guarantees the FIFO never overflows, so no result is ever dropped.
  - req_ready is a registered function of occupancy and does not depend combinationally on req_valid.
- Output handshake:
  - A pop occurs when rsp_valid and rsp_ready are both high at an edge.
  - rsp_ch and rsp_z must hold stable while rsp_valid=1 and rsp_ready=0.
  - Order is strict FIFO, i.e. acceptance order regardless of channel.
- Simultaneous accept and pop in the same edge: occupancy is unchanged, and req_ready stays high if it was high.
- Same-edge FIFO write and pop:
  - Full FIFO: the credit rule makes a write impossible while the FIFO is full.
  - Empty FIFO: a write becomes visible as rsp_valid the next cycle. There is no write-to-read bypass in the same cycle.
- Pointers: the FIFO pointers wrap modulo FIFO_DEPTH. Full/empty is distinguished by an extra pointer bit.
- busy = (occupancy != 0).
- Idle condition: the DPI polling loop treats busy=0 && rsp_valid=0 as "no result pending".
- Illegal parameters: LATENCY outside 1..4 or a non-power-of-two FIFO_DEPTH is caught by an elaboration-time assertion.

Test Plan:
- Single add: rst for 2 cycles, then one request ch=1, op=0, x=0xFF, y=0x01, with rsp_ready=1.
  - Required: rsp_valid rises LATENCY cycles after accept, with rsp_ch=1 and rsp_z=0x100.
  - busy returns to 0 one cycle after the pop.
- Subtract with borrow: op=1, x=0x05, y=0x07.
  - Required: rsp_z=0x1FE.
  - op=1, x=0x80, y=0x80 -> rsp_z=0x000.
- Back-pressure fill: hold rsp_ready=0 and issue 6 back-to-back requests, ch=0..3 then 0,1, with x=i, y=i.
  - Required: exactly 4 are accepted, req_ready drops after the 4th accept, and occupancy=4.
  - Then raise rsp_ready: results 0x000, 0x002, 0x004, 0x006 pop in order.
  - The remaining 2 requests are then accepted.
- Streaming throughput: rsp_ready=1 and req_valid=1 continuously for 32 requests, x=i, y=2i.
  - Required: one accept per cycle with req_ready never low.
  - 32 in-order results with z=3i.
- Output stability: rsp_valid=1 with rsp_ready toggling 0,0,1.
  - Required: rsp_ch and rsp_z are unchanged until the pop edge.
- Reset mid-operation: 3 requests accepted with 1 still in the pipeline, then assert rst for one cycle.
  - Required: rsp_valid=0, occupancy=0, busy=0 next cycle.
  - No stale result ever appears afterwards.
  - A fresh request x=0x10, y=0x20 returns 0x030.
